// File: rtl/generic_iob_debounce.sv
// rtl/generic_iob_debounce.sv - synchronise and debounce WIDTH pad inputs with edge pulses
module generic_iob_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 262144,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             event_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_w;

  state_e          state_q [WIDTH];
  state_e          state_d [WIDTH];
  logic [CW-1:0]   cnt_q   [WIDTH];
  logic [CW-1:0]   cnt_d   [WIDTH];

  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             event_q, event_d;

  // Synchroniser chain: pad_i is sampled only by stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {(SYNC_STAGES*WIDTH){RESET_LEVEL}};
    end else begin
      sync_q[0] <= pad_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Per-channel debounce FSM and counter; a change is accepted once the
  // synced value has differed from the level for DEBOUNCE_CYCLES+1 samples.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        STABLE: begin
          if (sync_w[k] != level_q[k]) begin
            state_d[k] = CHECK;
            cnt_d[k]   = CW'(1);
          end else begin
            cnt_d[k]   = '0;
          end
        end
        CHECK: begin
          if (sync_w[k] == level_q[k]) begin
            state_d[k] = STABLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_MAX) begin
            level_d[k] = ~level_q[k];
            rise_d[k]  = ~level_q[k];
            fall_d[k]  = level_q[k];
            state_d[k] = STABLE;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k]   = cnt_q[k] + CW'(1);
          end
        end
      endcase
    end
    event_d = |(rise_d | fall_d);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIDTH; k++) begin
        state_q[k] <= STABLE;
        cnt_q[k]   <= '0;
      end
      level_q <= {WIDTH{RESET_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= 1'b0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;

endmodule
